int_mul_iter_unit: RTL and testbench
====================================

# int_mul_iter_unit

Iterative unsigned shift-add multiplier with a val/rdy request/response interface. It sequences a single 2·p_nbits-wide adder, a left shifter and a right shifter over up to p_nbits cycles per transaction. Optional early termination ends the computation once the remaining multiplier bits are zero. It serves as the shared low-area multiply resource for processor and accelerator datapaths that tolerate multi-cycle latency.

## Interface
- p_nbits, 32, operand width; must be ≥ 2
- p_early_exit, 1, when 1, CALC ends as soon as the remaining multiplier is zero; when 0, CALC always runs p_nbits cycles
- clk  input  1  sole clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low: state resets on a rising clk edge while reset==0
- req_val  input  1  request valid
- req_rdy  output  1  unit can accept a request
- req_msg_a  input  p_nbits  multiplicand, unsigned
- req_msg_b  input  p_nbits  multiplier, unsigned
- resp_val  output  1  product valid
- resp_rdy  input  1  consumer accepts product
- resp_msg  output  2·p_nbits  full unsigned product a·b

## Operation
- State registers:
  - FSM: IDLE, CALC, DONE.
  - a_reg: 2·p_nbits wide.
  - b_reg: p_nbits wide.
  - acc: 2·p_nbits wide.
  - cnt: $clog2(p_nbits)+1 bits.
- IDLE:
  - req_rdy=1, resp_val=0.
  - On req_val && req_rdy: a_reg←zero-extended a, b_reg←b, acc←0, cnt←0, go to CALC.
- CALC (req_rdy=0, resp_val=0), each cycle:
  - If b_reg[0], acc←acc+a_reg (mod 2^(2·p_nbits)); otherwise acc unchanged.
  - a_reg←a_reg<<1.
  - b_reg←b_reg>>1.
  - cnt←cnt+1.
- Leave CALC for DONE at the end of the cycle in which either:
  - cnt==p_nbits-1, or
  - p_early_exit==1 and (b_reg>>1)==0.
- DONE:
  - resp_val=1, resp_msg=acc, req_rdy=0.
  - On resp_val && resp_rdy, go to IDLE.
  - acc is held until the next request is accepted.
- resp_msg always drives acc. It must be stable while resp_val && !resp_rdy.
- Arithmetic is unsigned only. The product always fits in 2·p_nbits bits, so no overflow flag exists.
- Reset (reset==0 at a rising edge), from any state:
  - FSM←IDLE, acc←0, a_reg←0, b_reg←0, cnt←0.
  - An in-flight transaction is dropped silently; no response is produced.
- While reset==0, req_val and resp_rdy are ignored.
- Values after the reset edge: req_rdy=1, resp_val=0, resp_msg=0.
- Outputs req_rdy and resp_val decode from the FSM state only. There are no combinational paths from req_val or resp_rdy to any output.

## Timing
- Acceptance edge T: req_val && req_rdy sampled high at T.
- CALC spans cycles T+1 … T+k.
- resp_val rises in cycle T+k+1.
- Value of k:
  - p_early_exit==0: k = p_nbits.
  - p_early_exit==1: k = max(1, msb_index(b)+1); b==0 gives k=1.
- Full latency (acceptance edge to resp_val high) is p_nbits+1 cycles. Minimum latency is 2.
- Response handshake completes at the edge where resp_val && resp_rdy. The FSM is back in IDLE (req_rdy=1) the following cycle.
- Back-to-back spacing:
  - A new request is accepted no earlier than one cycle after the response handshake.
  - Minimum initiation interval is k+2 cycles.
- No simultaneous request and response occurs: req_rdy and resp_val are mutually exclusive by construction.
- Requests presented during CALC or DONE are not accepted. Requesters must hold req_val and req_msg until req_rdy.
- Reset at the same edge as a request or response handshake: reset wins and the handshake has no effect.

## Test plan
- **Basic product.** p_nbits=32, early exit on: a=3, b=5 accepted at T → resp_val first high at T+4 with resp_msg=0x0000_0000_0000_000F; with early exit off → resp_val at T+33, same value.
- **Max operands.** a=b=0xFFFF_FFFF → resp_msg=0xFFFF_FFFE_0000_0001, resp_val at T+33 in both modes.
- **Zero multiplier.** a=0x1234_5678, b=0 → resp_msg=0 at T+2 with early exit on.
- **Backpressure.** a=7, b=6, resp_rdy held 0 for 10 cycles after resp_val rises → resp_val stays 1, resp_msg stays 42, req_rdy stays 0; resp_rdy=1 → req_rdy=1 on the next cycle.
- **Reset mid-CALC.** a=0xFFFF, b=0x8000_0000, reset=0 at T+5 → next cycle req_rdy=1, resp_val=0, resp_msg=0, no response ever appears; a subsequent a=2, b=9 request returns 18.
- **Randomized stream.** 500 random a/b pairs with random req_val/resp_rdy gaps → every product matches the golden model, in order, with per-transaction latency exactly k+1.

Source files
------------

// File: rtl/int_mul_iter_unit.sv
// rtl/int_mul_iter_unit.sv - iterative unsigned shift-add multiplier, val/rdy request/response
// One add per cycle over up to p_nbits cycles; optional early exit once the remaining multiplier is zero.
module int_mul_iter_unit #(
  parameter int p_nbits      = 32,
  parameter bit p_early_exit = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic [p_nbits-1:0]     req_msg_a,
  input  logic [p_nbits-1:0]     req_msg_b,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic [2*p_nbits-1:0]   resp_msg
);

  localparam int               cw       = $clog2(p_nbits) + 1;
  localparam logic [cw-1:0]    last_cnt = cw'(p_nbits - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state;
  logic [2*p_nbits-1:0]   a_reg;
  logic [2*p_nbits-1:0]   acc;
  logic [p_nbits-1:0]     b_reg;
  logic [cw-1:0]          cnt;
  logic [p_nbits-1:0]     b_next;
  logic                   finish;

  assign b_next   = b_reg >> 1;
  // Decided on the current b_reg so the last partial product still lands this cycle.
  assign finish   = (cnt == last_cnt) || (p_early_exit && (b_next == '0));
  assign resp_msg = acc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      req_rdy  <= 1'b1;
      resp_val <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val) begin
            a_reg   <= {{p_nbits{1'b0}}, req_msg_a};
            b_reg   <= req_msg_b;
            acc     <= '0;
            cnt     <= '0;
            state   <= CALC;
            req_rdy <= 1'b0;
          end
        end
        CALC: begin
          if (b_reg[0]) acc <= acc + a_reg;
          a_reg <= a_reg << 1;
          b_reg <= b_next;
          cnt   <= cnt + cw'(1);
          if (finish) begin
            state    <= DONE;
            resp_val <= 1'b1;
          end
        end
        DONE: begin
          if (resp_rdy) begin
            state    <= IDLE;
            resp_val <= 1'b0;
            req_rdy  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          req_rdy  <= 1'b1;
          resp_val <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_mul_iter_unit.sv
// tb/tb_int_mul_iter_unit.sv - self-checking bench for int_mul_iter_unit
// Instance 0 runs with early exit, instance 1 without; a cycle-level model checks both every cycle.
module tb_int_mul_iter_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv [2];
  logic        rr [2];
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic        rdy [2];
  logic        vld [2];
  logic [63:0] msg [2];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  int_mul_iter_unit #(.p_nbits(32), .p_early_exit(1'b1)) u_ee (
    .clk(clk), .reset(rst_n), .req_val(rv[0]), .req_rdy(rdy[0]),
    .req_msg_a(ra[0]), .req_msg_b(rb[0]), .resp_val(vld[0]),
    .resp_rdy(rr[0]), .resp_msg(msg[0])
  );

  int_mul_iter_unit #(.p_nbits(32), .p_early_exit(1'b0)) u_ne (
    .clk(clk), .reset(rst_n), .req_val(rv[1]), .req_rdy(rdy[1]),
    .req_msg_a(ra[1]), .req_msg_b(rb[1]), .resp_val(vld[1]),
    .resp_rdy(rr[1]), .resp_msg(msg[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycles spent computing: full width, or up to the highest set multiplier bit.
  function automatic int kcycles(input logic [31:0] b, input bit early);
    if (!early) return 32;
    for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
    return 1;
  endfunction

  // Model: 0 idle, 1 computing (mcnt cycles left), 2 holding a result
  int          mst   [2] = '{0, 0};
  int          mcnt  [2] = '{0, 0};
  int          mdone [2] = '{0, 0};
  logic [63:0] mprod [2];
  logic [63:0] mlast [2] = '{64'd0, 64'd0};

  task automatic model_step(input int m);
    chk($sformatf("m%0d req_rdy", m), {63'd0, rdy[m]}, {63'd0, mst[m] == 0});
    chk($sformatf("m%0d resp_val", m), {63'd0, vld[m]}, {63'd0, mst[m] == 2});
    if (mst[m] != 1) chk($sformatf("m%0d resp_msg", m), msg[m], mlast[m]);
    if (!rst_n) begin
      mst[m]   = 0;
      mlast[m] = 64'd0;
    end else if (mst[m] == 0) begin
      if (rv[m]) begin
        mst[m]   = 1;
        mcnt[m]  = kcycles(rb[m], m == 0);
        mprod[m] = {32'd0, ra[m]} * {32'd0, rb[m]};
      end
    end else if (mst[m] == 1) begin
      mcnt[m]--;
      if (mcnt[m] == 0) begin
        mst[m]   = 2;
        mlast[m] = mprod[m];
      end
    end else if (rr[m]) begin
      mst[m] = 0;
      mdone[m]++;
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic send(input int m, input logic [31:0] a, input logic [31:0] b, output bit ok);
    @(posedge clk); #1;
    rv[m] = 1'b1; ra[m] = a; rb[m] = b;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rdy[m]) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    rv[m] = 1'b0;
  endtask

  task automatic directed(input int m, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_lat, input int bp);
    bit ok;
    int lat;
    send(m, a, b, ok);
    chk("accept", {63'd0, ok}, 64'd1);
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (vld[m]) begin ok = 1'b1; break; end
    end
    chk("resp seen", {63'd0, ok}, 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("product", msg[m], exp);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp resp_val", {63'd0, vld[m]}, 64'd1);
      chk("bp resp_msg", msg[m], exp);
      chk("bp req_rdy", {63'd0, rdy[m]}, 64'd0);
    end
    @(posedge clk); #1; rr[m] = 1'b1;
    @(posedge clk); #1; rr[m] = 1'b0;
    @(negedge clk);
    chk("rdy after handshake", {63'd0, rdy[m]}, 64'd1);
    chk("val after handshake", {63'd0, vld[m]}, 64'd0);
  endtask

  bit stop_rr;

  task automatic rand_stream(input int m, input int n);
    int target;
    bit ok;
    target  = mdone[m] + n;
    stop_rr = 1'b0;
    fork
      begin
        for (int t = 0; t < n; t++) begin
          logic [31:0] a, b;
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            ra[m] = $urandom;
          end
          a = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
          b = $urandom >> $urandom_range(0, 31);
          if ($urandom_range(0, 15) == 0) b = 32'd0;
          if ($urandom_range(0, 15) == 0) b = 32'hFFFF_FFFF;
          send(m, a, b, ok);
          chk("stream accept", {63'd0, ok}, 64'd1);
        end
        for (int i = 0; i < 500 && mdone[m] < target; i++) @(negedge clk);
        chk("stream drained", 64'(mdone[m]), 64'(target));
        stop_rr = 1'b1;
      end
      begin
        while (!stop_rr) begin
          @(posedge clk); #1;
          rr[m] = 1'($urandom_range(0, 1));
        end
        rr[m] = 1'b0;
      end
    join
  endtask

  initial begin
    bit ok;
    for (int m = 0; m < 2; m++) begin
      rv[m] = 1'b0; rr[m] = 1'b0; ra[m] = 32'd0; rb[m] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    directed(0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 4, 0);
    directed(1, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 33, 0);
    directed(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 0);
    directed(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 0);
    directed(0, 32'h1234_5678, 32'd0, 64'd0, 2, 0);
    directed(0, 32'd7, 32'd6, 64'd42, 4, 10);

    send(0, 32'h0000_FFFF, 32'h8000_0000, ok);
    chk("rst txn accept", {63'd0, ok}, 64'd1);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset req_rdy", {63'd0, rdy[0]}, 64'd1);
    chk("post-reset resp_val", {63'd0, vld[0]}, 64'd0);
    chk("post-reset resp_msg", msg[0], 64'd0);
    repeat (40) @(negedge clk);
    chk("no resp after reset", {63'd0, vld[0]}, 64'd0);
    directed(0, 32'd2, 32'd9, 64'd18, 5, 0);

    rand_stream(0, 500);
    rand_stream(1, 60);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
